// File: rtl/uart_rx.sv
// UART receiver for 8N1 frames with OVS-times oversampling and a run-time selectable fixed baud rate.
// Every bit is sampled at its centre; good bytes pulse rx_valid, and a low stop bit pulses frame_err.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_fix,
    input  logic       rx_pin,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV_9600   = CLK_FREQ / (9600 * OVS);
    localparam int DIV_19200  = CLK_FREQ / (19200 * OVS);
    localparam int DIV_57600  = CLK_FREQ / (57600 * OVS);
    localparam int DIV_115200 = CLK_FREQ / (115200 * OVS);

    // The slowest rate has the largest divisor, so it sets the counter width.
    localparam int TW = $clog2(DIV_9600 + 1);
    localparam int OW = $clog2(OVS);

    localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);
    localparam logic [OW-1:0] OS_MID  = OW'(OVS / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          armed;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] div_m1;
    logic [TW-1:0] div_sel;
    logic [OW-1:0] os_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          tick;

    always_comb begin
        div_sel = TW'(DIV_9600);
        case (baud_fix)
            2'b00:   div_sel = TW'(DIV_9600);
            2'b01:   div_sel = TW'(DIV_19200);
            2'b10:   div_sel = TW'(DIV_57600);
            default: div_sel = TW'(DIV_115200);
        endcase
    end

    assign tick = (tick_cnt == div_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rxs     <= rx_meta;
        end
    end

    // armed stays low after a frame error until the line is seen idle again,
    // so a held break cannot be mistaken for a stream of start bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            div_m1    <= '0;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state != IDLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    os_cnt   <= '0;
                    if (armed && !rxs) begin
                        state  <= START;
                        busy   <= 1'b1;
                        armed  <= 1'b0;
                        div_m1 <= div_sel - TW'(1);
                    end else if (rxs) begin
                        armed <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (os_cnt == OS_MID) begin
                            os_cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                armed <= 1'b1;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end else begin
                            os_cnt <= os_cnt + OW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt             <= '0;
                            shift_reg[bit_idx] <= rxs;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            os_cnt <= os_cnt + OW'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
                            state  <= IDLE;
                            busy   <= 1'b0;
                            if (rxs) begin
                                data_out <= shift_reg;
                                rx_valid <= 1'b1;
                                armed    <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + OW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: good frames, false start, frame error with a held
// break, back-to-back frames, reset mid-frame, and a transmitter-style loopback send.
`timescale 1ns/1ps
module tb_uart_rx;
    // 18.432 MHz makes every divisor exact: 115200 -> 10 clk/tick, 19200 -> 60 clk/tick.
    localparam int CLK_FREQ = 18_432_000;
    localparam int BIT_FAST = 160;
    localparam int BIT_SLOW = 960;
    // 9.5 bits (1520) + 2 synchronizer clk + 1 detect clk, measured from the driven edge.
    localparam int LATENCY  = 1523;
    // 100 us at a 54.254 ns clock period.
    localparam int LOOP_BUDGET = 1843;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_fix;
    logic       rx_pin;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int valid_count = 0;
    int ferr_count = 0;
    int busy_count = 0;
    int last_valid_cycle = 0;
    int start_cycle = 0;
    int v0, f0, lat;
    logic [7:0] valid_data [0:31];
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .OVS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_fix  (baud_fix),
        .rx_pin    (rx_pin),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #27.127 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one 8N1 frame; must be called at a negedge and returns at a negedge, so
    // consecutive calls produce frames with no idle gap.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int bit_clks);
        start_cycle = cycle;
        rx_pin = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx_pin = stop_bit;
        repeat (bit_clks) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rx_valid || frame_err) checkOutput("pulse_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
        if (rx_valid) begin
            checkOutput("valid_width", {31'b0, prev_valid}, 32'd0);
            if (valid_count < 32) valid_data[valid_count] = data_out;
            valid_count++;
            last_valid_cycle = cycle;
        end
        if (frame_err) begin
            checkOutput("ferr_width", {31'b0, prev_ferr}, 32'd0);
            ferr_count++;
        end
        if (busy) busy_count++;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget exhausted, got %0d cycles, expected fewer", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_pin   = 1'b1;
        baud_fix = 2'b11;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out", {24'b0, data_out}, 32'h00);
        checkOutput("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("reset_frame_err", {31'b0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] good frame 0xA5 at 115200");
        v0 = valid_count; f0 = ferr_count;
        applyStimulus(8'hA5, 1'b1, BIT_FAST);
        repeat (20) @(negedge clk);
        checkOutput("A_valid_count", valid_count - v0, 32'd1);
        checkOutput("A_data_out", {24'b0, data_out}, 32'hA5);
        checkOutput("A_ferr_count", ferr_count - f0, 32'd0);
        lat = last_valid_cycle - start_cycle;
        checkOutput("A_latency_window", {31'b0, (lat >= LATENCY - 10) && (lat <= LATENCY + 10)}, 32'd1);

        $display("[TB] false start, 3 ticks low");
        v0 = valid_count; f0 = ferr_count;
        busy_count = 0;
        rx_pin = 1'b0;
        repeat (30) @(negedge clk);
        rx_pin = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("B_busy_during", {31'b0, busy}, 32'd1);
        repeat (60) @(negedge clk);
        checkOutput("B_busy_after", {31'b0, busy}, 32'd0);
        checkOutput("B_busy_cycles", busy_count, 32'd80);
        checkOutput("B_valid_count", valid_count - v0, 32'd0);
        checkOutput("B_ferr_count", ferr_count - f0, 32'd0);
        repeat (200) @(negedge clk);

        $display("[TB] 0x11 then 0x3C with low stop bit and held break");
        v0 = valid_count;
        applyStimulus(8'h11, 1'b1, BIT_FAST);
        repeat (20) @(negedge clk);
        checkOutput("C_first_valid", valid_count - v0, 32'd1);
        checkOutput("C_first_data", {24'b0, data_out}, 32'h11);
        v0 = valid_count; f0 = ferr_count;
        applyStimulus(8'h3C, 1'b0, BIT_FAST);
        busy_count = 0;
        repeat (3000) @(negedge clk);
        checkOutput("C_ferr_count", ferr_count - f0, 32'd1);
        checkOutput("C_valid_count", valid_count - v0, 32'd0);
        checkOutput("C_data_kept", {24'b0, data_out}, 32'h11);
        checkOutput("C_break_busy_cycles", busy_count, 32'd0);
        rx_pin = 1'b1;
        repeat (200) @(negedge clk);

        $display("[TB] back-to-back 0x00, 0xFF at 19200 with baud_fix wiggle mid-frame");
        baud_fix = 2'b01;
        v0 = valid_count; f0 = ferr_count;
        fork
            applyStimulus(8'h00, 1'b1, BIT_SLOW);
            begin
                repeat (3000) @(negedge clk);
                baud_fix = 2'b10;
                repeat (6000) @(negedge clk);
                baud_fix = 2'b01;
            end
        join
        applyStimulus(8'hFF, 1'b1, BIT_SLOW);
        repeat (50) @(negedge clk);
        checkOutput("D_valid_count", valid_count - v0, 32'd2);
        checkOutput("D_first_byte", {24'b0, valid_data[v0]}, 32'h00);
        checkOutput("D_second_byte", {24'b0, valid_data[v0 + 1]}, 32'hFF);
        checkOutput("D_ferr_count", ferr_count - f0, 32'd0);

        $display("[TB] reset during data bit 4, then fresh 0x5A");
        baud_fix = 2'b11;
        repeat (100) @(negedge clk);
        v0 = valid_count; f0 = ferr_count;
        rx_pin = 1'b0;
        repeat (BIT_FAST) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_pin = v0[0] ? 1'b0 : 1'b0;
            rx_pin = (8'h5A >> i) & 8'h01;
            repeat (BIT_FAST) @(negedge clk);
        end
        rx_pin = 1'b1;
        repeat (BIT_FAST / 2) @(negedge clk);
        checkOutput("E_busy_mid_frame", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("E_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("E_reset_data", {24'b0, data_out}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        checkOutput("E_abort_valid", valid_count - v0, 32'd0);
        checkOutput("E_abort_ferr", ferr_count - f0, 32'd0);
        applyStimulus(8'h5A, 1'b1, BIT_FAST);
        repeat (20) @(negedge clk);
        checkOutput("E_fresh_valid", valid_count - v0, 32'd1);
        checkOutput("E_fresh_data", {24'b0, data_out}, 32'h5A);

        $display("[TB] loopback send 0xA5 at 115200");
        v0 = valid_count; f0 = ferr_count;
        fork
            applyStimulus(8'hA5, 1'b1, BIT_FAST);
            begin
                for (int n = 0; n < LOOP_BUDGET && valid_count == v0; n++) @(negedge clk);
                checkOutput("F_valid_within_100us", {31'b0, valid_count > v0}, 32'd1);
                checkOutput("F_data_out", {24'b0, data_out}, 32'hA5);
            end
        join
        checkOutput("F_ferr_count", ferr_count - f0, 32'd0);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
